// File: rtl/bst_pkg.sv
// Shared types and constants for the bright-spot tracker.
package bst_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} bst_state_t;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int PIX_W = 12;
  localparam int CNT_W = 19;

  localparam logic [X_W-1:0] CENTRE_X = 10'd320;
  localparam logic [Y_W-1:0] CENTRE_Y = 9'd240;

endpackage

// File: rtl/frame_max_accum.sv
// Running per-frame maximum (value and position) plus bright-pixel counter.
module frame_max_accum
  import bst_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = 12'd3500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             accum,
  input  logic             clear,
  input  logic [PIX_W-1:0] pix,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  output logic [PIX_W-1:0] max_val,
  output logic [X_W-1:0]   max_x,
  output logic [Y_W-1:0]   max_y,
  output logic [CNT_W-1:0] bright_cnt
);

  logic [PIX_W-1:0] max_val_q, max_val_d;
  logic [X_W-1:0]   max_x_q, max_x_d;
  logic [Y_W-1:0]   max_y_q, max_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bright;

  assign bright = (pix >= THRESH);

  always_comb begin
    max_val_d = max_val_q;
    max_x_d   = max_x_q;
    max_y_d   = max_y_q;
    cnt_d     = cnt_q;
    if (clear) begin
      max_val_d = '0;
      max_x_d   = '0;
      max_y_d   = '0;
      cnt_d     = '0;
    end else if (load) begin
      max_val_d = pix;
      max_x_d   = x;
      max_y_d   = y;
      cnt_d     = CNT_W'(bright);
    end else if (accum) begin
      // Strictly greater only, so ties keep the earliest pixel in raster order.
      if (pix > max_val_q) begin
        max_val_d = pix;
        max_x_d   = x;
        max_y_d   = y;
      end
      cnt_d = cnt_q + CNT_W'(bright);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q <= '0;
      max_x_q   <= '0;
      max_y_q   <= '0;
      cnt_q     <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_x_q   <= max_x_d;
      max_y_q   <= max_y_d;
      cnt_q     <= cnt_d;
    end
  end

  assign max_val    = max_val_q;
  assign max_x      = max_x_q;
  assign max_y      = max_y_q;
  assign bright_cnt = cnt_q;

endmodule

// File: rtl/bright_spot_tracker.sv
// Finds the brightest pixel of each frame and publishes its coordinates at frame end,
// with a found flag and a lock flag that survives up to LOST_LIMIT-1 missed frames.
module bright_spot_tracker
  import bst_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH     = 12'd3500,
  parameter int               MIN_PIXELS = 4,
  parameter int               X_MAX      = 639,
  parameter int               Y_MAX      = 479,
  parameter int               LOST_LIMIT = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [PIX_W-1:0] iGRAY,
  input  logic             iDVAL,
  input  logic [10:0]      iX_Cont,
  input  logic [10:0]      iY_Cont,
  output logic [X_W-1:0]   oSPOT_X,
  output logic [Y_W-1:0]   oSPOT_Y,
  output logic             oFOUND,
  output logic             oLOCK,
  output logic             oFRAME_DONE
);

  localparam int MISS_W = $clog2(LOST_LIMIT + 1);

  // Only the downsampled coordinate bits are kept; the rest are don't-care.
  logic unused_cont;
  assign unused_cont = ^{iX_Cont[0], iY_Cont[0], iY_Cont[10]};

  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic           at_origin, at_end;

  bst_state_t state_q, state_d;
  logic       acc_load, acc_accum, acc_clear;

  logic [PIX_W-1:0] max_val;
  logic [X_W-1:0]   max_x;
  logic [Y_W-1:0]   max_y;
  logic [CNT_W-1:0] bright_cnt;
  logic             hit;

  logic [X_W-1:0]    spot_x_q, spot_x_d;
  logic [Y_W-1:0]    spot_y_q, spot_y_d;
  logic              found_q, found_d;
  logic              lock_q, lock_d;
  logic              done_q, done_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  // Counters lead the grayscale data by one cycle, so delay them to line up.
  always_comb begin
    pix_x_d = iX_Cont[10:1];
    pix_y_d = iY_Cont[9:1];
  end

  always_ff @(posedge iCLK) begin
    pix_x_q <= pix_x_d;
    pix_y_q <= pix_y_d;
  end

  assign at_origin = (pix_x_q == '0) && (pix_y_q == '0);
  assign at_end    = (pix_x_q == X_W'(X_MAX)) && (pix_y_q == Y_W'(Y_MAX));

  always_comb begin
    state_d   = state_q;
    acc_load  = 1'b0;
    acc_accum = 1'b0;
    acc_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (iDVAL && at_origin) begin
          acc_load = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (iDVAL) begin
          // A fresh origin mid-scan means the previous frame was truncated.
          if (at_origin) begin
            acc_load = 1'b1;
          end else begin
            acc_accum = 1'b1;
            if (at_end) state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        acc_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  frame_max_accum #(
    .THRESH(THRESH)
  ) u_accum (
    .clk       (iCLK),
    .rst       (iRST),
    .load      (acc_load),
    .accum     (acc_accum),
    .clear     (acc_clear),
    .pix       (iGRAY),
    .x         (pix_x_q),
    .y         (pix_y_q),
    .max_val   (max_val),
    .max_x     (max_x),
    .max_y     (max_y),
    .bright_cnt(bright_cnt)
  );

  assign hit = (max_val >= THRESH) && (bright_cnt >= CNT_W'(MIN_PIXELS));

  always_comb begin
    spot_x_d = spot_x_q;
    spot_y_d = spot_y_q;
    found_d  = found_q;
    lock_d   = lock_q;
    miss_d   = miss_q;
    done_d   = 1'b0;
    if (state_q == COMMIT) begin
      done_d = 1'b1;
      if (hit) begin
        spot_x_d = max_x;
        spot_y_d = max_y;
        found_d  = 1'b1;
        miss_d   = '0;
        lock_d   = 1'b1;
      end else begin
        found_d = 1'b0;
        if (miss_q < MISS_W'(LOST_LIMIT)) miss_d = miss_q + MISS_W'(1);
        if (miss_d >= MISS_W'(LOST_LIMIT)) lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      spot_x_q <= CENTRE_X;
      spot_y_q <= CENTRE_Y;
      found_q  <= 1'b0;
      lock_q   <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= MISS_W'(LOST_LIMIT);
    end else begin
      spot_x_q <= spot_x_d;
      spot_y_q <= spot_y_d;
      found_q  <= found_d;
      lock_q   <= lock_d;
      done_q   <= done_d;
      miss_q   <= miss_d;
    end
  end

  assign oSPOT_X     = spot_x_q;
  assign oSPOT_Y     = spot_y_q;
  assign oFOUND      = found_q;
  assign oLOCK       = lock_q;
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_bright_spot_tracker.sv
// Bench for bright_spot_tracker: table-driven frames, hand-written corner sequences,
// and random sparse frames checked against a list-based reference model.
module tb_bright_spot_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] gray;
  logic        dval;
  logic [10:0] xc, yc;
  logic [9:0]  sx;
  logic [8:0]  sy;
  logic        found, lock, done;

  always #5 clk = ~clk;

  bright_spot_tracker dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iGRAY      (gray),
    .iDVAL      (dval),
    .iX_Cont    (xc),
    .iY_Cont    (yc),
    .oSPOT_X    (sx),
    .oSPOT_Y    (sy),
    .oFOUND     (found),
    .oLOCK      (lock),
    .oFRAME_DONE(done)
  );

  typedef struct {int x; int y; int v;} px_t;
  typedef struct {int bg; int bx; int by; int w; int h; int v;
                  int ef; int ex; int ey; int el;} tv_t;

  px_t frame_q[$];
  int  tests = 0, fails = 0, done_cnt = 0;
  int  m_x, m_y, m_found, m_miss, m_lock;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_found = 0; m_miss = 8; m_lock = 0;
  endtask

  // Reference: brightest earliest pixel of the list, bright count, hit/miss bookkeeping.
  task automatic model_commit();
    int best = -1, bx = 0, by = 0, cnt = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].v > best) begin
        best = frame_q[i].v; bx = frame_q[i].x; by = frame_q[i].y;
      end
      if (frame_q[i].v >= 3500) cnt++;
    end
    if (best >= 3500 && cnt >= 4) begin
      m_x = bx; m_y = by; m_found = 1; m_miss = 0; m_lock = 1;
    end else begin
      m_found = 0;
      if (m_miss < 8) m_miss++;
      if (m_miss >= 8) m_lock = 0;
    end
  endtask

  task automatic send_px(input int x, input int y, input int v);
    @(negedge clk);
    dval = 1'b0;
    xc   = 11'(2 * x);
    yc   = 11'(2 * y);
    @(negedge clk);
    gray = 12'(v);
    dval = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dval = 1'b0;
    end
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_px(frame_q[i].x, frame_q[i].y, frame_q[i].v);
  endtask

  task automatic build_block(input int bg, input int bx, input int by,
                             input int w, input int h, input int v);
    frame_q.delete();
    frame_q.push_back('{0, 0, bg});
    for (int r = by; r < by + h; r++)
      for (int c = bx; c < bx + w; c++)
        frame_q.push_back('{c, r, v});
    frame_q.push_back('{639, 479, bg});
  endtask

  // Called right after the last pixel's valid cycle: pulse must land exactly at N+2.
  task automatic check_commit(input string nm, input int ex, input int ey,
                              input int ef, input int el);
    @(negedge clk);
    dval = 1'b0;
    chk({nm, "_done_n1"}, int'(done), 0);
    @(negedge clk);
    chk({nm, "_done_n2"}, int'(done), 1);
    chk({nm, "_x"}, int'(sx), ex);
    chk({nm, "_y"}, int'(sy), ey);
    chk({nm, "_found"}, int'(found), ef);
    chk({nm, "_lock"}, int'(lock), el);
    @(negedge clk);
    chk({nm, "_done_n3"}, int'(done), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    dval = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_x"}, int'(sx), 320);
    chk({nm, "_y"}, int'(sy), 240);
    chk({nm, "_found"}, int'(found), 0);
    chk({nm, "_lock"}, int'(lock), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  tv_t tbl[8];

  initial begin
    int dc0;
    rst = 1'b1; dval = 1'b0; gray = '0; xc = '0; yc = '0;
    tbl[0] = '{100,  300, 200, 3, 3,  100, 0, 320, 240, 0};
    tbl[1] = '{100,  200, 150, 3, 3, 4000, 1, 200, 150, 1};
    tbl[2] = '{100,  400, 300, 1, 1, 4095, 0, 200, 150, 1};
    tbl[3] = '{100,    5,   7, 2, 2, 3500, 1,   5,   7, 1};
    tbl[4] = '{100,  100, 100, 3, 1, 3500, 0,   5,   7, 1};
    tbl[5] = '{100,   20,  30, 2, 2, 3499, 0,   5,   7, 1};
    tbl[6] = '{4095,  10,  10, 3, 1, 4095, 1,   0,   0, 1};
    tbl[7] = '{0,    637, 477, 2, 2, 4000, 1, 637, 477, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_reset_vals("por");

    dc0 = done_cnt;
    foreach (tbl[i]) begin
      build_block(tbl[i].bg, tbl[i].bx, tbl[i].by, tbl[i].w, tbl[i].h, tbl[i].v);
      send_frame();
      check_commit($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ef, tbl[i].el);
    end
    chk("tbl_done_count", done_cnt - dc0, 8);

    // Equal maxima: the earlier one in raster order wins.
    do_reset();
    frame_q.delete();
    frame_q.push_back('{0, 0, 100});
    frame_q.push_back('{10, 5, 4000});
    frame_q.push_back('{50, 50, 3600});
    frame_q.push_back('{300, 300, 3600});
    frame_q.push_back('{600, 400, 4000});
    frame_q.push_back('{639, 479, 100});
    send_frame();
    check_commit("tie", 10, 5, 1, 1);

    // Eight consecutive misses after a hit drop the lock on the eighth.
    for (int k = 1; k <= 8; k++) begin
      build_block(100, 400, 300, 1, 1, 4095);
      send_frame();
      check_commit($sformatf("miss%0d", k), 10, 5, 0, (k < 8) ? 1 : 0);
    end

    // Truncated frame: origin reappears, partial data is discarded, one commit only.
    do_reset();
    dc0 = done_cnt;
    build_block(100, 50, 60, 3, 3, 4000);
    frame_q.push_front('{300, 199, 100});
    frame_q.push_front('{101, 101, 4095});
    frame_q.push_front('{100, 101, 4095});
    frame_q.push_front('{101, 100, 4095});
    frame_q.push_front('{100, 100, 4095});
    frame_q.push_front('{0, 0, 100});
    send_frame();
    check_commit("trunc", 50, 60, 1, 1);
    idle(3);
    chk("trunc_done_count", done_cnt - dc0, 1);

    // Reset in the middle of a frame.
    do_reset();
    build_block(100, 200, 150, 3, 3, 4000);
    send_frame();
    check_commit("pre_rst", 200, 150, 1, 1);
    send_px(0, 0, 100);
    send_px(210, 160, 4095);
    send_px(211, 160, 4095);
    @(negedge clk);
    dval = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_reset_vals("midrst");
    dc0 = done_cnt;
    send_px(212, 160, 4095);
    send_px(213, 160, 4095);
    send_px(639, 479, 100);
    idle(5);
    chk("midrst_no_commit", done_cnt - dc0, 0);
    chk("midrst_x_held", int'(sx), 320);
    build_block(100, 70, 80, 2, 2, 4000);
    send_frame();
    check_commit("post_rst", 70, 80, 1, 1);

    // Random sparse frames against the reference model.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int pos, r, v;
      frame_q.delete();
      frame_q.push_back('{0, 0, int'($urandom_range(0, 4095))});
      pos = 0;
      while (1) begin
        pos += int'($urandom_range(1, 40000));
        if (pos >= 307199) break;
        r = int'($urandom_range(0, 9));
        if (r < 3)      v = 4000;
        else if (r < 6) v = int'($urandom_range(3400, 4095));
        else            v = int'($urandom_range(0, 3499));
        frame_q.push_back('{pos % 640, pos / 640, v});
      end
      frame_q.push_back('{639, 479, int'($urandom_range(0, 4095))});
      send_frame();
      model_commit();
      check_commit($sformatf("rnd%0d", f), m_x, m_y, m_found, m_lock);
      idle(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
